// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte interface among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to build the stall timeout that revokes a grant (pulses abort).
module uart_tx_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 24_000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              abort
);
    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;

    logic [IW-1:0]   gidx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   next_ptr;
    logic            any_valid;
    logic            tx_free;
    logic            accept;
    logic [7:0]      sel_data;
    logic            sel_last;
    logic            timeout;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
    end

    // First active requester at or above rr_ptr, wrapping around.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    assign tx_free   = !tx_valid_q || tx_ready;
    assign req_ready = (state_q == StStream && tx_free) ? grant_q : '0;
    assign accept    = |(req_ready & req_valid);
    assign sel_data  = req_data[{gidx, 3'b000} +: 8];
    assign sel_last  = req_last[gidx];
    assign next_ptr  = IW'((int'(gidx) + 1) % NREQ);

    // The TX holding register runs independently of the FSM so a last byte can drain in IDLE.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = sel_data;
        end else if (tx_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StStream;
                    grant_d = NREQ'(1) << pick;
                end
            end
            StStream: begin
                if ((accept && sel_last) || timeout) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q;

    // Only an absent owner counts; back-pressure from tx_ready holds the count.
    always_comb begin
        cnt_d   = cnt_q;
        timeout = 1'b0;
        if (state_q != StStream || accept) begin
            cnt_d = '0;
        end else if (!req_valid[gidx]) begin
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            abort_q <= timeout;
        end
    end

    assign abort = abort_q;
`else
    assign timeout = 1'b0;
    assign abort   = 1'b0;
`endif

    assign grant    = grant_q;
    assign busy     = (state_q == StStream);
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: owner-level reference model plus directed scenarios.
// Honours UART_ARB_TIMEOUT_EN the same way as the design.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic              clk;
    logic              n_reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              abort;

    uart_tx_arbiter #(
        .NREQ           (NREQ),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .abort     (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: who owns the transmitter and what byte sits in the TX register.
    typedef struct {
        int         owner;  // -1 when nobody holds the grant
        int         ptr;
        bit         txv;
        logic [7:0] txd;
        bit         abrt;
        int         stall;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.owner = -1; r.ptr = 0; r.txv = 1'b0; r.txd = 8'h00; r.abrt = 1'b0; r.stall = 0;
        return r;
    endfunction

    function automatic model_t step(model_t s, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                                    logic rdy);
        model_t n = s;
        bit take;
        n.abrt = 1'b0;
        take = (s.owner >= 0) && v[s.owner] && (!s.txv || rdy);
        if (take) begin
            n.txv = 1'b1;
            n.txd = d[8*s.owner +: 8];
        end else if (rdy) begin
            n.txv = 1'b0;
        end
        if (s.owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (n.owner < 0 && v[(s.ptr + k) % NREQ]) begin
                    n.owner = (s.ptr + k) % NREQ;
                    n.stall = 0;
                end
            end
        end else if (take) begin
            n.stall = 0;
            if (l[s.owner]) begin
                n.owner = -1;
                n.ptr   = (s.owner + 1) % NREQ;
            end
        end else if (!v[s.owner]) begin
`ifdef UART_ARB_TIMEOUT_EN
            if (s.stall == TMO - 1) begin
                n.owner = -1;
                n.ptr   = (s.owner + 1) % NREQ;
                n.abrt  = 1'b1;
                n.stall = 0;
            end else begin
                n.stall = s.stall + 1;
            end
`endif
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_grant(model_t s);
        return (s.owner >= 0) ? 4'(1 << s.owner) : 4'h0;
    endfunction

    function automatic logic [3:0] exp_ready(model_t s, logic rdy);
        return (s.owner >= 0 && (!s.txv || rdy)) ? 4'(1 << s.owner) : 4'h0;
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) m <= model_reset();
        else          m <= step(m, req_valid, req_data, req_last, tx_ready);
    end

    always @(negedge clk) begin
        if (n_reset) begin
            check("mdl_grant", 32'(grant), 32'(exp_grant(m)));
            check("mdl_busy", 32'(busy), 32'(m.owner >= 0));
            check("mdl_req_ready", 32'(req_ready), 32'(exp_ready(m, tx_ready)));
            check("mdl_tx_valid", 32'(tx_valid), 32'(m.txv));
            check("mdl_tx_data", 32'(tx_data), 32'(m.txd));
            check("mdl_abort", 32'(abort), 32'(m.abrt));
        end
    end

    // Requester sources: each presents the head of its queue until accepted.
    logic [8:0]      q [NREQ][$];
    logic [NREQ-1:0] fire;
    logic [8:0]      head;
    int              acc_cyc [NREQ];

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            fire = n_reset ? (req_valid & req_ready) : '0;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (fire[i]) begin
                    void'(q[i].pop_front());
                    acc_cyc[i] = cyc;
                end
                req_valid[i] = (q[i].size() != 0);
                if (q[i].size() != 0) begin
                    head               = q[i][0];
                    req_data[8*i +: 8] = head[7:0];
                    req_last[i]        = head[8];
                end
            end
        end
    end

    logic [7:0] tx_log [$];

    always @(posedge clk) begin
        if (n_reset && tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    task automatic push(input int i, input logic [7:0] b, input logic l);
        q[i].push_back({l, b});
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        n_reset  = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) q[i].delete();
        tx_log.delete();
        repeat (2) @(posedge clk);
        #2;
        n_reset = 1'b1;
    endtask

    task automatic wait_log(input int k, input string name);
        int n = 0;
        while (tx_log.size() < k && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(tx_log.size()), 32'(k));
    endtask

    // Expected bytes packed first-byte-in-LSB.
    task automatic check_log(input string name, input int n, input logic [63:0] bytes);
        check({name, "_len"}, 32'(tx_log.size()), 32'(n));
        for (int k = 0; k < n && k < tx_log.size(); k++) begin
            check(name, 32'(tx_log[k]), 32'(bytes[8*k +: 8]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        check({tag, "_abort"}, 32'(abort), 32'h0);
    endtask

    logic [7:0] held;
    logic [3:0] prev;
    logic [3:0] gr_seen [$];
    int         gr_cyc [$];
    logic [3:0] exp_tr [7];
    bit         found;
    int         ab_cyc;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        n_reset  = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #2;
        n_reset = 1'b1;

        // Requester 1 alone: A B C.
        @(posedge clk);
        #2;
        push(1, 8'h41, 1'b0); push(1, 8'h42, 1'b0); push(1, 8'h43, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("t1_no_grant_yet", 32'(grant), 32'h0);
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'h2);
        check("t1_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_tx_data", 32'(tx_data), 32'h41 + 32'(k));
            check("t1_tx_valid", 32'(tx_valid), 32'h1);
        end
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);
        // rr_ptr is now 2, so requester 3 beats requester 0.
        repeat (3) @(posedge clk);
        #2;
        tx_log.delete();
        push(0, 8'hD0, 1'b1); push(3, 8'hD3, 1'b1);
        wait_log(2, "t1_ptr_wait");
        check_log("t1_ptr_order", 2, 64'hD0D3);

        // Requesters 0 and 2 from reset, two-byte packets each.
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b1);
        exp_tr = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0};
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t2_grant_trace", 32'(grant), 32'(exp_tr[k]));
        end
        wait_log(4, "t2_wait");
        check_log("t2_order", 4, 64'hC1C0A1A0);

        // tx_ready stalled mid-packet.
        do_reset();
        for (int k = 0; k < 5; k++) push(1, 8'h10 + 8'(k), (k == 4));
        wait_log(1, "t3_wait_first");
        @(posedge clk);
        #2;
        tx_ready = 1'b0;
        held     = tx_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_hold_data", 32'(tx_data), 32'(held));
            check("t3_hold_valid", 32'(tx_valid), 32'h1);
            check("t3_backpressure", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #2;
        tx_ready = 1'b1;
        wait_log(5, "t3_wait_all");
        check_log("t3_order", 5, 64'h1413121110);

        // All four requesters with back-to-back one-byte packets.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            push(i, 8'h50 + 8'(i), 1'b1);
            push(i, 8'h58 + 8'(i), 1'b1);
        end
        prev = '0;
        gr_seen.delete();
        gr_cyc.delete();
        repeat (30) begin
            @(negedge clk);
            if (grant != 4'h0 && grant != prev) begin
                gr_seen.push_back(grant);
                gr_cyc.push_back(cyc);
            end
            prev = grant;
        end
        check("t4_grant_count", 32'(gr_seen.size()), 32'd8);
        for (int k = 0; k < 8 && k < gr_seen.size(); k++) begin
            check("t4_rotation", 32'(gr_seen[k]), 32'(1) << (k % 4));
            if (k > 0) check("t4_spacing", 32'(gr_cyc[k] - gr_cyc[k-1]), 32'd2);
        end
        wait_log(8, "t4_wait");
        check_log("t4_order", 8, 64'h5B5A595853525150);

        // Requester 3 goes silent mid-packet while requester 0 waits.
        do_reset();
        push(3, 8'h77, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (grant == 4'h8) found = 1'b1;
        end
        check("t5_grant3", 32'(grant), 32'h8);
        @(posedge clk);
        #2;
        push(0, 8'h66, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
        found = 1'b0;
        ab_cyc = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (abort === 1'b1) begin
                found  = 1'b1;
                ab_cyc = cyc;
            end
        end
        check("t5_abort_seen", 32'(found), 32'h1);
        check("t5_abort_delay", 32'(ab_cyc - acc_cyc[3]), 32'(TMO));
        check("t5_grant_cleared", 32'(grant), 32'h0);
        @(negedge clk);
        check("t5_abort_one_cycle", 32'(abort), 32'h0);
        check("t5_grant0", 32'(grant), 32'h1);
        wait_log(2, "t5_wait");
        check_log("t5_order", 2, 64'h6677);
`else
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t5_grant_held", 32'(grant), 32'h8);
        check("t5_no_abort", 32'(abort), 32'h0);
        @(posedge clk);
        #2;
        push(3, 8'h78, 1'b1);
        wait_log(3, "t5_wait");
        check_log("t5_order", 3, 64'h667877);
`endif

        // Asynchronous reset mid-packet; arbitration restarts from pointer 0.
        do_reset();
        push(2, 8'hE2, 1'b1);
        wait_log(1, "t6_wait_e2");
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 4; k++) push(1, 8'hF0 + 8'(k), (k == 3));
        wait_log(2, "t6_wait_mid");
        @(posedge clk);
        #3;
        check("t6_pre_tx_valid", 32'(tx_valid), 32'h1);
        n_reset = 1'b0;
        #1;
        check_reset_vals("t6_async");
        for (int i = 0; i < NREQ; i++) q[i].delete();
        tx_log.delete();
        repeat (2) @(posedge clk);
        #2;
        n_reset = 1'b1;
        push(1, 8'hF5, 1'b1);
        push(3, 8'hF7, 1'b1);
        wait_log(2, "t6_wait_after");
        check_log("t6_order", 2, 64'hF7F5);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter inside `top` between up to `NREQ` byte-stream requesters, such as a command responder, a status reporter and a trigger logger. Arbitration is round-robin at packet granularity. A granted requester keeps the transmitter until it hands over a byte flagged `last`, so packets from different sources never interleave on `uart_txd`. The block sits between the requesters and the UART TX byte interface and runs in the `clk24` domain.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, default 24_000: stall limit in cycles for the timeout feature (1 ms at 24 MHz); legal range ≥ 2.
- `clk`  in  1  system clock (24 MHz).
- `n_reset`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  requester i presents a byte.
- `req_data`  in  8*NREQ  byte of requester i, located at bits [8i+7:8i].
- `req_last`  in  NREQ  the byte of requester i is the last byte of its packet.
- `req_ready`  out  NREQ  byte of requester i is accepted this cycle.
- `tx_valid`  out  1  byte available for the UART transmitter.
- `tx_data`  out  8  byte for the UART transmitter.
- `tx_ready`  in  1  UART transmitter accepts `tx_data` this cycle.
- `grant`  out  NREQ  one-hot current owner; all zero when idle.
- `busy`  out  1  high while in STREAM.
- `abort`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Handshakes on both sides use valid/ready. A transfer happens when valid and ready are both high on a rising edge. Once a source raises valid, it holds valid and data stable until ready.
- FSM has two states.
  - **IDLE**: if any `req_valid` is high, select the first active index, searching upward from `rr_ptr` with wrap-around. Set `grant` to that index (one-hot) and go to STREAM. If no `req_valid` is high, stay in IDLE.
  - **STREAM**: `req_ready[g] = grant[g] & (!tx_valid | tx_ready)`. All other `req_ready` bits are 0.
- Accepting a byte in STREAM loads `tx_data` from the granted requester and sets `tx_valid` to 1.
- When the accepted byte has `req_last[g]=1`:
  - go to IDLE;
  - clear `grant`;
  - set `rr_ptr = (g+1) mod NREQ`.
- `tx_valid` falls on `tx_ready` unless a new byte is loaded in the same cycle.
- `tx_valid`/`tx_data` are independent of FSM state. A last byte may still be pending on the TX side while IDLE arbitrates the next packet.
- Requests that arrive while in STREAM wait. They do not affect the current grant.
- `req_valid` dropping mid-packet does not release the grant; only `last` or a timeout releases it.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, `busy`=0, `req_ready`=0, `tx_valid`=0, `tx_data`=8'h00, `abort`=0, timeout counter 0.
- Arbitration latency: `req_valid` sampled high in IDLE produces `grant`/`busy` on the next cycle. `req_ready` can go high in that same next cycle.
- Datapath latency: a byte accepted at edge N appears as `tx_valid` after edge N.
- Throughput: one byte per cycle while `tx_ready`=1.
- Gap between packets: exactly one IDLE cycle per packet.
- When `tx_ready`=0 and `tx_valid`=1, `req_ready`=0 (back-pressure); `tx_data` is held.
- If `n_reset` is asserted mid-packet, all state clears immediately. A partially sent packet is dropped, and there is no resumption.

## Configuration
- `UART_ARB_TIMEOUT_EN` **defined**:
  - In STREAM, a counter increments on each cycle where `req_valid[g]`=0.
  - The counter clears on every accepted byte and on entering STREAM.
  - Starvation by `tx_ready`=0 does not count.
  - When the counter reaches `TIMEOUT_CYCLES-1` with `req_valid[g]` still 0, the next edge does all of the following:
    - goes to IDLE and clears `grant`;
    - sets `rr_ptr=(g+1) mod NREQ`;
    - pulses `abort` for one cycle.
  - A byte already in `tx_data` is still delivered.
- `UART_ARB_TIMEOUT_EN` **undefined**:
  - No counter is built; the grant is held indefinitely.
  - `abort` is tied to 0.
  - `TIMEOUT_CYCLES` is ignored.

## Test plan
- Requester 1 alone sends 0x41, 0x42, 0x43 (last on 0x43) with `tx_ready`=1:
  - `grant`=4'b0010 one cycle after `req_valid`;
  - `tx_data` carries 0x41, 0x42, 0x43 on consecutive cycles;
  - afterwards IDLE with `rr_ptr`=2.
- Requesters 0 and 2 both request from reset, each with a 2-byte packet:
  - the packet from 0 goes out first, then one IDLE cycle, then the packet from 2;
  - no interleaving.
- `tx_ready` held 0 for 10 cycles mid-packet:
  - `tx_data` is stable;
  - `req_ready`=0 throughout;
  - no byte lost or duplicated after release.
- All 4 requesters hold continuous 1-byte packets: grants rotate 0, 1, 2, 3, 0, one every 2 cycles.
- With the macro defined and `TIMEOUT_CYCLES`=8, requester 3 sends one non-last byte and then drops `req_valid`:
  - `abort` pulses 8 cycles after that byte's acceptance;
  - `grant` clears;
  - a waiting requester 0 is granted next.
- `n_reset` pulsed low while requester 1 is mid-packet with `tx_valid`=1:
  - all outputs reach reset values asynchronously;
  - after release, arbitration restarts from `rr_ptr`=0.
